// File: rtl/uart_parity_engine.sv
// UART parity generator/checker: accumulates serial data bits per frame and then
// either presents a parity bit (TX) or checks a received one (RX).
module uart_parity_engine #(
  parameter int MAX_DATA_BITS = 9
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       start_i,
  input  logic [4:0] data_bits_i,
  input  logic [2:0] mode_i,
  input  logic       dir_i,
  input  logic       bit_i,
  input  logic       valid_i,
  output logic       parity_bit_o,
  output logic       parity_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       parity_err_o
);

  localparam int CW = $clog2(MAX_DATA_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Reserved encodings collapse to "none" so later logic only sees 000..100.
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    if (m > 3'd4) begin
      return 3'd0;
    end else begin
      return m;
    end
  endfunction

  function automatic logic parity_of(input logic [2:0] m, input logic acc);
    case (m)
      3'd1:    return ~acc;
      3'd2:    return acc;
      3'd3:    return 1'b1;
      3'd4:    return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic            r_acc;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_n;
  logic [2:0]      r_mode;
  logic            r_dir;
  logic            r_err;
  logic [CW-1:0]   w_n_eff;
  logic            w_last;
  logic            w_parity;

  // Requested frame length clamped into the supported range
  always_comb begin
    if (data_bits_i < 5'd5) begin
      w_n_eff = CW'(5);
    end else if (data_bits_i > 5'(MAX_DATA_BITS)) begin
      w_n_eff = CW'(MAX_DATA_BITS);
    end else begin
      w_n_eff = CW'(data_bits_i);
    end
  end

  assign w_last   = (r_cnt == (r_n - CW'(1)));
  assign w_parity = parity_of(r_mode, r_acc);

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start_i restarts the frame from any state
  always_comb begin
    w_next = r_state;
    if (start_i) begin
      w_next = S_DATA;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_IDLE;
        S_DATA: begin
          if (valid_i && w_last) begin
            w_next = (r_mode == 3'd0) ? S_DONE : S_PARITY;
          end else begin
            w_next = S_DATA;
          end
        end
        S_PARITY: w_next = valid_i ? S_DONE : S_PARITY;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Frame datapath: configuration, accumulator, bit counter, sticky error
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_acc  <= 1'b0;
      r_cnt  <= '0;
      r_n    <= CW'(MAX_DATA_BITS);
      r_mode <= 3'd0;
      r_dir  <= 1'b0;
      r_err  <= 1'b0;
    end else if (start_i) begin
      r_acc  <= 1'b0;
      r_cnt  <= '0;
      r_n    <= w_n_eff;
      r_mode <= norm_mode(mode_i);
      r_dir  <= dir_i;
      r_err  <= 1'b0;
    end else if (r_state == S_DATA && valid_i) begin
      r_acc <= r_acc ^ bit_i;
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == S_PARITY && valid_i && r_dir) begin
      r_err <= (bit_i != w_parity);
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    parity_bit_o   = w_parity;
    parity_valid_o = (r_state == S_PARITY);
    busy_o         = (r_state != S_IDLE);
    done_o         = (r_state == S_DONE);
    parity_err_o   = r_err;
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Bench for uart_parity_engine: directed vector table, hand-written corner
// sequences, then random frames checked against a popcount-based model.
module tb_uart_parity_engine;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       start_i;
  logic [4:0] data_bits_i;
  logic [2:0] mode_i;
  logic       dir_i;
  logic       bit_i;
  logic       valid_i;
  logic       parity_bit_o;
  logic       parity_valid_o;
  logic       busy_o;
  logic       done_o;
  logic       parity_err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  nbits;
    logic [2:0]  mode;
    logic        dir;
    logic [15:0] data;
    logic        rx;
    logic        exp_pb;
    logic        exp_err;
    logic        exp_par;
  } vec_t;

  uart_parity_engine #(.MAX_DATA_BITS(9)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .data_bits_i(data_bits_i),
    .mode_i(mode_i), .dir_i(dir_i), .bit_i(bit_i), .valid_i(valid_i),
    .parity_bit_o(parity_bit_o), .parity_valid_o(parity_valid_o), .busy_o(busy_o),
    .done_o(done_o), .parity_err_o(parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int clamp_n(input logic [4:0] nb);
    int n = int'(nb);
    if (n < 5) n = 5;
    if (n > 9) n = 9;
    return n;
  endfunction

  // Reference: parity from the population count of the first N data bits
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int n = clamp_n(v.nbits);
    int ones = 0;
    int m = (v.mode > 3'd4) ? 0 : int'(v.mode);
    for (int i = 0; i < n; i++) ones += int'(v.data[i]);
    case (m)
      1:       r.exp_pb = (ones % 2 == 0);
      2:       r.exp_pb = (ones % 2 == 1);
      3:       r.exp_pb = 1'b1;
      default: r.exp_pb = 1'b0;
    endcase
    r.exp_par = (m != 0);
    r.exp_err = v.dir && r.exp_par && (v.rx != r.exp_pb);
    return r;
  endfunction

  // Sends n data bits (with random gaps), handles parity, checks done/err.
  // With chain set, start_i is raised in the DONE cycle instead of idling.
  task automatic frame_body(input int n, input vec_t v, input string nm, input logic chain);
    for (int i = 0; i < n; i++) begin
      int g = int'($urandom_range(0, 1));
      for (int k = 0; k < g; k++) begin
        valid_i = 1'b0;
        @(negedge clk_i);
      end
      valid_i = 1'b1;
      bit_i   = v.data[i];
      @(negedge clk_i);
      valid_i = 1'b0;
      if (i < n - 1) begin
        chk({nm, ".pv_early"}, 16'(parity_valid_o), 16'd0);
        chk({nm, ".done_early"}, 16'(done_o), 16'd0);
      end
    end
    if (v.exp_par) begin
      int h = int'($urandom_range(0, 2));
      chk({nm, ".pv"}, 16'(parity_valid_o), 16'd1);
      chk({nm, ".pb"}, 16'(parity_bit_o), 16'(v.exp_pb));
      for (int k = 0; k < h; k++) begin
        bit_i = ~v.rx;
        @(negedge clk_i);
        chk({nm, ".pv_hold"}, 16'(parity_valid_o), 16'd1);
      end
      valid_i = 1'b1;
      bit_i   = v.rx;
      @(negedge clk_i);
      valid_i = 1'b0;
    end else begin
      chk({nm, ".pv_none"}, 16'(parity_valid_o), 16'd0);
    end
    chk({nm, ".done"}, 16'(done_o), 16'd1);
    chk({nm, ".err"}, 16'(parity_err_o), 16'(v.exp_err));
    chk({nm, ".pb_done"}, 16'(parity_bit_o), 16'(v.exp_pb));
    if (chain) begin
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk({nm, ".chain_done"}, 16'(done_o), 16'd0);
      chk({nm, ".chain_busy"}, 16'(busy_o), 16'd1);
    end else begin
      @(negedge clk_i);
      chk({nm, ".done_pulse"}, 16'(done_o), 16'd0);
      chk({nm, ".idle"}, 16'(busy_o), 16'd0);
      chk({nm, ".err_sticky"}, 16'(parity_err_o), 16'(v.exp_err));
    end
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    @(negedge clk_i);
    start_i     = 1'b1;
    data_bits_i = v.nbits;
    mode_i      = v.mode;
    dir_i       = v.dir;
    valid_i     = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    chk({nm, ".busy"}, 16'(busy_o), 16'd1);
    frame_body(clamp_n(v.nbits), v, nm, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".pb"}, 16'(parity_bit_o), 16'd0);
    chk({nm, ".pv"}, 16'(parity_valid_o), 16'd0);
    chk({nm, ".busy"}, 16'(busy_o), 16'd0);
    chk({nm, ".done"}, 16'(done_o), 16'd0);
    chk({nm, ".err"}, 16'(parity_err_o), 16'd0);
  endtask

  vec_t tbl[11];
  vec_t v;

  initial begin
    // nbits, mode, dir, data, rx, exp_pb, exp_err, exp_par
    tbl[0]  = '{5'd8,  3'd2, 1'b0, 16'h00A7, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{5'd7,  3'd1, 1'b1, 16'h0055, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{5'd7,  3'd1, 1'b1, 16'h0055, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{5'd5,  3'd0, 1'b0, 16'h001F, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{5'd9,  3'd3, 1'b0, 16'h01FF, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{5'd9,  3'd4, 1'b0, 16'h01FF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{5'd3,  3'd2, 1'b0, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{5'd20, 3'd1, 1'b0, 16'h01FF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{5'd6,  3'd7, 1'b1, 16'h003F, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{5'd8,  3'd2, 1'b1, 16'h00A7, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{5'd16, 3'd1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1};

    rstn_i = 1'b0; start_i = 1'b0; data_bits_i = 5'd0; mode_i = 3'd0;
    dir_i = 1'b0; bit_i = 1'b0; valid_i = 1'b0;
    #1;
    chk_all_zero("in_reset");
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk_all_zero("after_reset");

    for (int i = 0; i < 11; i++) begin
      run_frame(tbl[i], $sformatf("vec%0d", i));
    end

    // Sticky error survives idle, cleared by reset
    run_frame(tbl[1], "err_frame");
    @(negedge clk_i);
    chk("err_idle_sticky", 16'(parity_err_o), 16'd1);
    rstn_i = 1'b0;
    #1;
    chk_all_zero("reset_idle");
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Abort on the 4th bit: start_i wins over valid_i, frame restarts cleanly
    @(negedge clk_i);
    start_i = 1'b1; data_bits_i = 5'd8; mode_i = 3'd2; dir_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; bit_i = 1'b1;
      @(negedge clk_i);
    end
    start_i = 1'b1; valid_i = 1'b1; bit_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; valid_i = 1'b0;
    chk("abort.done", 16'(done_o), 16'd0);
    chk("abort.busy", 16'(busy_o), 16'd1);
    chk("abort.pv", 16'(parity_valid_o), 16'd0);
    v = '{5'd8, 3'd2, 1'b0, 16'h003C, 1'b0, 1'b0, 1'b0, 1'b1};
    frame_body(8, v, "abort_frame", 1'b0);

    // start_i during DONE: done still pulses, next frame begins immediately
    v = '{5'd5, 3'd0, 1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 1'b0};
    @(negedge clk_i);
    start_i = 1'b1; data_bits_i = v.nbits; mode_i = v.mode; dir_i = v.dir;
    @(negedge clk_i);
    start_i = 1'b0;
    frame_body(5, v, "chain_a", 1'b1);
    frame_body(5, v, "chain_b", 1'b0);

    // Reset while parity is being presented discards the frame at once
    @(negedge clk_i);
    start_i = 1'b1; data_bits_i = 5'd9; mode_i = 3'd3; dir_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      valid_i = 1'b1; bit_i = 1'b1;
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    chk("mid.pv", 16'(parity_valid_o), 16'd1);
    chk("mid.pb", 16'(parity_bit_o), 16'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset.done", 16'(done_o), 16'd0);
    chk("post_reset.busy", 16'(busy_o), 16'd0);

    for (int i = 0; i < 40; i++) begin
      v.nbits = 5'($urandom_range(0, 31));
      v.mode  = 3'($urandom_range(0, 7));
      v.dir   = 1'($urandom_range(0, 1));
      v.data  = 16'($urandom);
      v.rx    = 1'($urandom_range(0, 1));
      v = model(v);
      run_frame(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
